// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes and the decoded-entry record.
// Optional M-extension decode is enabled with the RV_DECODE_M_EN macro (see rv_decode_comb).
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] NOP_OPCODE = OPC_OP_IMM;

  typedef enum logic [3:0] {
    ALU_R   = 4'd0,
    ALU_I   = 4'd1,
    LUI     = 4'd2,
    AUIPC   = 4'd3,
    JAL     = 4'd4,
    JALR    = 4'd5,
    BRANCH  = 4'd6,
    LOAD    = 4'd7,
    STORE   = 4'd8,
    MULDIV  = 4'd9,
    ILLEGAL = 4'd10
  } iclass_e;

  // Immediate and PC are kept outside the record so their width can follow XLEN.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] opcode;
    iclass_e    iclass;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
  } decoded_t;

  function automatic decoded_t empty_entry();
    decoded_t e;
    e        = '0;
    e.opcode = NOP_OPCODE;
    e.iclass = ALU_R;
    return e;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I instruction decoder: raw instruction -> decoded record + immediate.
// Define RV_DECODE_M_EN to accept OP funct7=0000001 (multiply/divide) as MULDIV.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output decoded_t        entry,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        legal;
  decoded_t    d;
  logic [31:0] imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    d      = '0;
    d.iclass = ALU_R;
    d.opcode = opc;
    imm32  = '0;
    legal  = 1'b0;
    case (opc)
      OPC_OP: begin
        d.iclass = ALU_R;
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
        d.funct3 = f3; d.funct7 = f7;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1;
        if (f7 == 7'b0000000)
          legal = 1'b1;
        else if (f7 == 7'b0100000)
          legal = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef RV_DECODE_M_EN
        else if (f7 == 7'b0000001) begin
          legal    = 1'b1;
          d.iclass = MULDIV;
        end
`endif
      end
      OPC_OP_IMM: begin
        d.iclass = ALU_I;
        d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.funct3 = f3;
        d.uses_rs1 = 1'b1; d.writes_rd = 1'b1;
        if (f3 == 3'b001) begin
          d.funct7 = f7; imm32 = imm_sh;
          legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          d.funct7 = f7; imm32 = imm_sh;
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end else begin
          imm32 = imm_i; legal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        d.iclass = (opc == OPC_LUI) ? LUI : AUIPC;
        d.rd = instr[11:7]; d.writes_rd = 1'b1;
        imm32 = imm_u; legal = 1'b1;
      end
      OPC_JAL: begin
        d.iclass = JAL;
        d.rd = instr[11:7]; d.writes_rd = 1'b1;
        imm32 = imm_j; legal = 1'b1;
      end
      OPC_JALR: begin
        d.iclass = JALR;
        d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.funct3 = f3;
        d.uses_rs1 = 1'b1; d.writes_rd = 1'b1;
        imm32 = imm_i; legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.iclass = BRANCH;
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.funct3 = f3;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        imm32 = imm_b; legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_LOAD: begin
        d.iclass = LOAD;
        d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.funct3 = f3;
        d.uses_rs1 = 1'b1; d.writes_rd = 1'b1;
        imm32 = imm_i;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        d.iclass = STORE;
        d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.funct3 = f3;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        imm32 = imm_s; legal = (f3 <= 3'b010);
      end
      default: legal = 1'b0;
    endcase

    if (d.rd == 5'd0)
      d.writes_rd = 1'b0;

    // Illegal encodings still travel downstream, scrubbed to a NOP-group record.
    if (!legal || (instr[1:0] != 2'b11)) begin
      d         = '0;
      d.opcode  = NOP_OPCODE;
      d.iclass  = ILLEGAL;
      d.illegal = 1'b1;
      imm32     = '0;
    end

    entry = d;
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered valid/ready RV32I decode stage with a DEPTH-entry output FIFO and flush.
// Define RV_DECODE_M_EN to decode M-extension OP instructions as MULDIV.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] imm_out,
  output logic [3:0]      iclass,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            writes_rd,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  decoded_t        dec;
  logic [XLEN-1:0] dec_imm;

  rv_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .entry (dec),
    .imm   (dec_imm)
  );

  decoded_t        ent_mem [DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    return p + PTR_W'(1);
  endfunction

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= ptr_inc(wptr);
      if (pop)
        rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_mem[wptr] <= dec;
      imm_mem[wptr] <= dec_imm;
      pc_mem[wptr]  <= in_pc;
    end
  end

  // Storage is not reset; an empty FIFO presents the reset-default record instead.
  decoded_t        head;
  logic [XLEN-1:0] head_imm, head_pc;

  always_comb begin
    head     = empty_entry();
    head_imm = '0;
    head_pc  = '0;
    if (out_valid) begin
      head     = ent_mem[rptr];
      head_imm = imm_mem[rptr];
      head_pc  = pc_mem[rptr];
    end
  end

  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign funct3    = head.funct3;
  assign funct7    = head.funct7;
  assign opcode    = head.opcode;
  assign iclass    = head.iclass;
  assign uses_rs1  = head.uses_rs1;
  assign uses_rs2  = head.uses_rs2;
  assign writes_rd = head.writes_rd;
  assign illegal   = head.illegal;
  assign imm_out   = head_imm;
  assign pc_out    = head_pc;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed cases plus randomized traffic vs a reference decoder.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  localparam int DEPTH = 2;
`ifdef RV_DECODE_M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, imm_out, pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7, opcode;
  logic [3:0]  iclass;
  logic        uses_rs1, uses_rs2, writes_rd, illegal;
  logic        rand_mode = 1'b0, force_ready = 1'b1, rnd_ready = 1'b1;

  assign out_ready = rand_mode ? rnd_ready : force_ready;

  always #5 clk = ~clk;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  rv_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .imm_out(imm_out), .iclass(iclass), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .writes_rd(writes_rd), .illegal(illegal), .pc_out(pc_out)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    logic [3:0]  cls;
    logic        u1, u2, wr, ill;
    logic [31:0] imm, pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  function automatic longint sgn(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference decoder: field extraction and immediates as signed integer arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t   e;
    int     op, f3, f7;
    longint imm_v;
    bit     ok;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    e = '{default: '0};
    imm_v = 0;
    ok = 1'b1;
    case (op)
      'h33: begin
        e.cls = ALU_R; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.f3 = ins[14:12]; e.f7 = ins[31:25]; e.u1 = 1; e.u2 = 1; e.wr = 1;
        if (f7 == 'h20) ok = (f3 == 0 || f3 == 5);
        else if (f7 == 1) begin ok = M_EN; e.cls = MULDIV; end
        else ok = (f7 == 0);
      end
      'h13: begin
        e.cls = ALU_I; e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        e.u1 = 1; e.wr = 1;
        if (f3 == 1 || f3 == 5) begin
          e.f7 = ins[31:25]; imm_v = longint'(ins[24:20]);
          ok = (f7 == 0) || (f3 == 5 && f7 == 'h20);
        end else imm_v = sgn(longint'(ins[31:20]), 12);
      end
      'h37, 'h17: begin
        e.cls = (op == 'h37) ? LUI : AUIPC; e.rd = ins[11:7]; e.wr = 1;
        imm_v = sgn(longint'(ins[31:12]), 20) * 4096;
      end
      'h6f: begin
        e.cls = JAL; e.rd = ins[11:7]; e.wr = 1;
        imm_v = sgn(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      'h67: begin
        e.cls = JALR; e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        e.u1 = 1; e.wr = 1; imm_v = sgn(longint'(ins[31:20]), 12); ok = (f3 == 0);
      end
      'h63: begin
        e.cls = BRANCH; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
        e.u1 = 1; e.u2 = 1; ok = !(f3 inside {2, 3});
        imm_v = sgn(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      'h03: begin
        e.cls = LOAD; e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        e.u1 = 1; e.wr = 1; imm_v = sgn(longint'(ins[31:20]), 12); ok = !(f3 inside {3, 6, 7});
      end
      'h23: begin
        e.cls = STORE; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
        e.u1 = 1; e.u2 = 1; ok = (f3 <= 2);
        imm_v = sgn(longint'(f7) * 32 + longint'(ins[11:7]), 12);
      end
      default: ok = 1'b0;
    endcase
    if (ins[1:0] != 2'b11) ok = 1'b0;
    if (e.rd == 0) e.wr = 0;
    e.imm = imm_v[31:0];
    e.opc = ins[6:0];
    if (!ok) begin
      e = '{default: '0};
      e.opc = 7'h13; e.cls = ILLEGAL; e.ill = 1;
    end
    e.pc = pc;
    return e;
  endfunction

  // Monitor: status vs model occupancy, pop/compare head, then record acceptances.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, sb.size() > 0);
      chk("in_ready", in_ready, sb.size() < DEPTH);
      if (out_valid && out_ready && !flush && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rs1", rs1, e.rs1);       chk("rs2", rs2, e.rs2);     chk("rd", rd, e.rd);
        chk("funct3", funct3, e.f3);  chk("funct7", funct7, e.f7);
        chk("opcode", opcode, e.opc); chk("iclass", iclass, e.cls);
        chk("imm_out", imm_out, e.imm);
        chk("uses_rs1", uses_rs1, e.u1); chk("uses_rs2", uses_rs2, e.u2);
        chk("writes_rd", writes_rd, e.wr); chk("illegal", illegal, e.ill);
        chk("pc_out", pc_out, e.pc);
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    do begin
      acc = in_ready && !flush;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) bound_fail("send_accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) bound_fail("drain");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0); chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_opcode"}, opcode, 7'h13);   chk({tag, "_rd"}, rd, 0);
    chk({tag, "_imm"}, imm_out, 0);         chk({tag, "_iclass"}, iclass, 0);
    chk({tag, "_illegal"}, illegal, 0);     chk({tag, "_pc"}, pc_out, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs [9];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = opcs[k];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed decode checks; each entry is at the head right after acceptance.
    send(32'hFFF00093, 32'h100);
    chk("addi_valid", out_valid, 1); chk("addi_rd", rd, 1); chk("addi_rs1", rs1, 0);
    chk("addi_imm", imm_out, 32'hFFFFFFFF); chk("addi_cls", iclass, ALU_I);
    chk("addi_wr", writes_rd, 1);
    send(32'hFE208EE3, 32'h104);
    chk("beq_imm", imm_out, 32'hFFFFFFFC); chk("beq_rs1", rs1, 1); chk("beq_rs2", rs2, 2);
    chk("beq_wr", writes_rd, 0); chk("beq_cls", iclass, BRANCH);
    send(32'h001000EF, 32'h108);
    chk("jal_imm", imm_out, 32'h800); chk("jal_rd", rd, 1);
    send(32'h12345037, 32'h10C);
    chk("lui_x0_wr", writes_rd, 0); chk("lui_imm", imm_out, 32'h12345000);
    drain();

    // Backpressure: two accepts fill the FIFO, a third is held off.
    force_ready = 1'b0;
    send(32'h00100113, 32'h200);
    send(32'h00200193, 32'h204);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_instr = 32'h00300213; in_pc = 32'h208;
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_in_ready", in_ready, 0);
    end
    force_ready = 1'b1;
    send(32'h00300213, 32'h208);
    drain();

    send(32'hFFFFFFFF, 32'h300);
    chk("ill_ff_flag", illegal, 1); chk("ill_ff_cls", iclass, ILLEGAL); chk("ill_ff_pc", pc_out, 32'h300);
    send(32'h00007083, 32'h304);
    chk("ill_ld_flag", illegal, 1); chk("ill_ld_cls", iclass, ILLEGAL); chk("ill_ld_pc", pc_out, 32'h304);
    drain();

    // Flush with two buffered entries; the concurrent in_valid is ignored.
    force_ready = 1'b0;
    send(32'h00500293, 32'h400);
    send(32'h00600313, 32'h404);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700393;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0); chk("flush_in_ready", in_ready, 1);
    force_ready = 1'b1;

    send(32'h022081B3, 32'h500);
    chk("mul_cls", iclass, M_EN ? MULDIV : ILLEGAL); chk("mul_illegal", illegal, !M_EN);
    drain();

    // Randomized traffic with random backpressure, idles and flushes.
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rand_instr(), $urandom);
      if ($urandom_range(0, 29) == 0) begin
        flush = 1'b1; in_valid = $urandom_range(0, 1); in_instr = $urandom;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_mode = 1'b0;

    // Asynchronous reset with entries buffered.
    force_ready = 1'b0;
    send(32'h00100093, 32'h600);
    send(32'h00200113, 32'h604);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_ready = 1'b1;
    send(32'h00800413, 32'h700);
    chk("post_rst_imm", imm_out, 8); chk("post_rst_pc", pc_out, 32'h700);
    drain();
    chk("sb_leftover", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
